// File: rtl/bird_pixel_gen.sv
// bird_pixel_gen: Flappy Bird bird physics, IDLE/FLY/DEAD control and registered pixel colour.
module bird_pixel_gen #(
  parameter int BIRD_X = 160,
  parameter int BIRD_SIZE = 16,
  parameter int START_Y = 232,
  parameter int GROUND_Y = 440,
  parameter int GRAVITY = 1,
  parameter int FLAP_V = 8,
  parameter int MAX_FALL = 12,
  parameter int V_REFRESH = 481,
  parameter logic [2:0] SKY_COLOR = 3'b011,
  parameter logic [2:0] BIRD_COLOR = 3'b110,
  parameter logic [2:0] GROUND_COLOR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       flap,
  output logic [2:0] rgb,
  output logic [9:0] bird_y,
  output logic       dead
);
  localparam logic [1:0] IDLE = 2'd0, FLY = 2'd1, DEAD = 2'd2;
  localparam logic signed [5:0] FLAP_VEL = 6'(-FLAP_V);
  localparam logic signed [5:0] MAX_VEL = 6'(MAX_FALL);
  localparam logic signed [5:0] GRAV = 6'(GRAVITY);
  localparam logic signed [10:0] SIZE_S = 11'(BIRD_SIZE);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  logic [1:0] state, state_n;
  logic signed [5:0] vel, vel_n, vel_inc;
  logic signed [10:0] next_y;
  logic [9:0] bird_y_n;
  logic flap_s1, flap_s2, flap_d, flap_edge, flap_pend, flap_now, refr_tick, in_bird;
  logic [2:0] rgb_n;
  assign refr_tick = p_tick && pixel_x == 10'd0 && pixel_y == 10'(V_REFRESH);
  assign flap_edge = flap_s2 & ~flap_d;
  // an edge arriving on the tick cycle itself still counts for that tick
  assign flap_now = flap_pend | flap_edge;
  assign vel_inc = vel + GRAV;
  assign next_y = $signed({1'b0, bird_y}) + $signed({{5{vel[5]}}, vel});
  assign dead = state == DEAD;
  always_comb begin
    state_n = state;
    vel_n = vel;
    bird_y_n = bird_y;
    if (refr_tick) begin
      if (state == IDLE) begin
        state_n = flap_now ? FLY : IDLE;
        vel_n = flap_now ? FLAP_VEL : vel;
      end else if (state == FLY) begin
        vel_n = flap_now ? FLAP_VEL : (vel_inc > MAX_VEL ? MAX_VEL : vel_inc);
        if (next_y + SIZE_S > GROUND_S) begin
          bird_y_n = 10'(GROUND_Y - BIRD_SIZE);
          vel_n = '0;
          state_n = DEAD;
        end else begin
          bird_y_n = next_y < 0 ? 10'd0 : next_y[9:0];
        end
      end else if (state == DEAD) begin
        state_n = flap_now ? IDLE : DEAD;
        bird_y_n = flap_now ? 10'(START_Y) : bird_y;
        vel_n = flap_now ? 6'sd0 : vel;
      end else begin
        state_n = IDLE;
      end
    end
  end
  assign in_bird = pixel_x >= 10'(BIRD_X) && pixel_x < 10'(BIRD_X + BIRD_SIZE) &&
                   pixel_y >= bird_y && {1'b0, pixel_y} < {1'b0, bird_y} + 11'(BIRD_SIZE);
  assign rgb_n = !video_on ? 3'b000 : in_bird ? BIRD_COLOR :
                 pixel_y >= 10'(GROUND_Y) ? GROUND_COLOR : SKY_COLOR;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= 3'b000;
      bird_y <= 10'(START_Y);
      vel <= '0;
      state <= IDLE;
      flap_s1 <= 1'b0;
      flap_s2 <= 1'b0;
      flap_d <= 1'b0;
      flap_pend <= 1'b0;
    end else begin
      rgb <= rgb_n;
      bird_y <= bird_y_n;
      vel <= vel_n;
      state <= state_n;
      flap_s1 <= flap;
      flap_s2 <= flap_s1;
      flap_d <= flap_s2;
      flap_pend <= refr_tick ? 1'b0 : flap_pend | flap_edge;
    end
  end
endmodule

// File: tb/tb_bird_pixel_gen.sv
// tb_bird_pixel_gen: randomized and directed checks of bird_pixel_gen against a frame-level model.
module tb_bird_pixel_gen;
  logic clk = 1'b0, reset = 1'b1, p_tick = 1'b0, video_on = 1'b0, flap = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic [2:0] rgb;
  logic [9:0] bird_y;
  logic dead;
  int checks = 0, errors = 0;
  int m_y = 232, m_vel = 0, m_state = 0;
  bird_pixel_gen dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .flap(flap),
    .rgb(rgb), .bird_y(bird_y), .dead(dead)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void model_reset();
    m_y = 232;
    m_vel = 0;
    m_state = 0;
  endfunction
  // one frame of game rules: 0 idle, 1 flying, 2 dead
  function automatic void model_tick(input bit f);
    int nxt;
    if (m_state == 0) begin
      if (f) begin m_state = 1; m_vel = -8; end
    end else if (m_state == 1) begin
      nxt = m_y + m_vel;
      m_vel = f ? -8 : (m_vel + 1 > 12 ? 12 : m_vel + 1);
      if (nxt + 16 > 440) begin m_y = 424; m_vel = 0; m_state = 2; end
      else m_y = nxt < 0 ? 0 : nxt;
    end else if (f) begin
      m_state = 0; m_y = 232; m_vel = 0;
    end
  endfunction
  function automatic logic [2:0] ref_color(input int x, input int y, input int by, input bit von);
    if (!von) return 3'b000;
    if (x >= 160 && x < 176 && y >= by && y < by + 16) return 3'b110;
    if (y >= 440) return 3'b010;
    return 3'b011;
  endfunction
  task automatic do_frame(input int pulses);
    for (int i = 0; i < pulses; i++) begin
      flap = 1'b1;
      repeat (3) step();
      flap = 1'b0;
      repeat (3) step();
    end
    repeat (4) step();
    pixel_x = 10'd0; pixel_y = 10'd481; p_tick = 1'b1;
    step();
    p_tick = 1'b0; pixel_y = 10'd0;
    step();
    model_tick(pulses > 0);
  endtask
  task automatic test_reset();
    reset = 1'b1; video_on = 1'b1; pixel_x = 10'd165; pixel_y = 10'd240;
    repeat (5) step();
    checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b expected 000", rgb); end
    checks++; if (bird_y !== 10'd232) begin errors++; $display("FAIL reset_y: got %0d expected 232", bird_y); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL reset_dead: got %b expected 0", dead); end
    reset = 1'b0; video_on = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      do_frame(0);
      checks++; if (bird_y !== 10'd232 || dead !== 1'b0) begin
        errors++; $display("FAIL idle_hold frame %0d: got y=%0d dead=%b expected y=232 dead=0", k, bird_y, dead);
      end
    end
  endtask
  task automatic test_start_rise();
    int exp_y [3] = '{232, 224, 217};
    for (int k = 0; k < 3; k++) begin
      do_frame(k == 0 ? 3 : 0);
      checks++; if (bird_y !== 10'(exp_y[k]) || bird_y !== 10'(m_y) || dead !== 1'b0) begin
        errors++; $display("FAIL rise tick %0d: got y=%0d dead=%b expected y=%0d dead=0", k + 1, bird_y, dead, exp_y[k]);
      end
    end
  endtask
  task automatic test_fall();
    int n = 0;
    while (m_state != 2 && n < 60) begin
      do_frame(0);
      n++;
      checks++; if (bird_y !== 10'(m_y) || dead !== (m_state == 2)) begin
        errors++; $display("FAIL fall frame %0d: got y=%0d dead=%b expected y=%0d dead=%b", n, bird_y, dead, m_y, m_state == 2);
      end
    end
    checks++; if (bird_y !== 10'd424 || dead !== 1'b1) begin
      errors++; $display("FAIL landing: got y=%0d dead=%b expected y=424 dead=1 (frames %0d)", bird_y, dead, n);
    end
    for (int k = 0; k < 5; k++) begin
      do_frame(0);
      checks++; if (bird_y !== 10'd424 || dead !== 1'b1) begin
        errors++; $display("FAIL dead_hold %0d: got y=%0d dead=%b expected y=424 dead=1", k, bird_y, dead);
      end
    end
    do_frame(1);
    checks++; if (bird_y !== 10'd232 || dead !== 1'b0) begin
      errors++; $display("FAIL restart: got y=%0d dead=%b expected y=232 dead=0", bird_y, dead);
    end
    do_frame(0);
    checks++; if (bird_y !== 10'd232) begin
      errors++; $display("FAIL restart_idle: got y=%0d expected 232", bird_y);
    end
  endtask
  task automatic test_ceiling();
    do_frame(1);
    for (int k = 0; k < 32; k++) begin
      do_frame(1);
      checks++; if (bird_y !== 10'(m_y) || dead !== 1'b0) begin
        errors++; $display("FAIL ceiling frame %0d: got y=%0d dead=%b expected y=%0d dead=0", k, bird_y, dead, m_y);
      end
    end
    checks++; if (bird_y !== 10'd0 || dead !== 1'b0) begin
      errors++; $display("FAIL ceiling_clamp: got y=%0d dead=%b expected y=0 dead=0", bird_y, dead);
    end
    for (int k = 0; k < 12; k++) begin
      do_frame(0);
      checks++; if (bird_y !== 10'(m_y) || dead !== 1'b0) begin
        errors++; $display("FAIL ceiling_release %0d: got y=%0d dead=%b expected y=%0d", k, bird_y, dead, m_y);
      end
    end
  endtask
  task automatic test_pixels();
    int px [8] = '{165, 10, 10, 165, 159, 160, 175, 176};
    int py [8] = '{240, 450, 10, 240, 232, 231, 247, 248};
    bit pv [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    logic [2:0] pe [4] = '{3'b110, 3'b010, 3'b011, 3'b000};
    logic [2:0] exp_c;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 38; k++) begin
      pixel_x = k < 8 ? 10'(px[k]) : 10'($urandom_range(799));
      pixel_y = k < 8 ? 10'(py[k]) : 10'($urandom_range(216, 479));
      video_on = k < 8 ? pv[k] : ($urandom_range(9) != 0);
      exp_c = ref_color(pixel_x, pixel_y, m_y, video_on);
      step();
      checks++; if (rgb !== exp_c || (k < 4 && rgb !== pe[k])) begin
        errors++; $display("FAIL pixel (%0d,%0d,v=%b): got %b expected %b", pixel_x, pixel_y, video_on, rgb, exp_c);
      end
    end
    video_on = 1'b0; pixel_x = '0; pixel_y = '0;
  endtask
  task automatic test_reset_midflight();
    bit pat [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    do_frame(1);
    for (int k = 0; k < 8; k++) do_frame(pat[k] ? 1 : 0);
    checks++; if (bird_y !== 10'd180 || m_y != 180) begin
      errors++; $display("FAIL midflight_pos: got y=%0d model=%0d expected 180", bird_y, m_y);
    end
    flap = 1'b1;
    repeat (3) step();
    flap = 1'b0;
    repeat (3) step();
    video_on = 1'b1; pixel_x = 10'd10; pixel_y = 10'd10;
    step();
    #2 reset = 1'b1;
    #1;
    checks++; if (rgb !== 3'b000 || bird_y !== 10'd232) begin
      errors++; $display("FAIL async_reset: got rgb=%b y=%0d expected rgb=000 y=232", rgb, bird_y);
    end
    model_reset();
    repeat (2) step();
    reset = 1'b0; video_on = 1'b0;
    for (int k = 0; k < 2; k++) begin
      do_frame(0);
      checks++; if (bird_y !== 10'd232 || dead !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle %0d: got y=%0d dead=%b expected y=232 dead=0", k, bird_y, dead);
      end
    end
  endtask
  initial begin
    test_reset();
    test_start_rise();
    test_fall();
    test_ceiling();
    test_pixels();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
